// File: rtl/warships_pkg.sv
// rtl/warships_pkg.sv - shared event/state types for the board click receiver
package warships_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    START  = 2'd1,
    PLAYER = 2'd2,
    ENEMY  = 2'd3
  } evt_type_t;

  localparam logic [7:0] COORD_NONE = 8'hFF;

  typedef struct packed {
    evt_type_t  evt_type;
    logic [3:0] x;
    logic [3:0] y;
  } click_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_WAIT_REL = 2'd2
  } rx_state_t;

endpackage

// File: rtl/click_fifo.sv
// rtl/click_fifo.sv - 2-entry FIFO, type-parameterised; simultaneous push+pop allowed when full
module click_fifo #(
  parameter type T = logic [9:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  T           mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/board_click_rx.sv
// rtl/board_click_rx.sv - debounced click/start event receiver with 2-entry event FIFO
// Optional coordinate range check enabled by macro CLICK_RX_RANGE_CHECK_EN.
module board_click_rx
  import warships_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GRID_CELLS      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic [7:0] player_cor,
  input  logic [7:0] enemy_cor,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [3:0] evt_x,
  output logic [3:0] evt_y,
  output logic       evt_overflow
);

`ifdef CLICK_RX_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam logic [3:0] DEB      = 4'(DEBOUNCE_CYCLES);
  localparam logic [4:0] GRID_LIM = 5'(GRID_CELLS);

  click_evt_t sample;
  logic       sample_idle;
  logic       in_range;

  rx_state_t  state_q, state_d;
  click_evt_t cand_q, cand_d;
  logic [3:0] qcnt_q, qcnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       push;

  click_evt_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       overflow_q;

  assign in_range = ({1'b0, sample.x} < GRID_LIM) && ({1'b0, sample.y} < GRID_LIM);

  // Priority: start > enemy > player; anything else (or an out-of-range cell) is IDLE.
  always_comb begin
    sample = '0;
    if (start_btn) begin
      sample.evt_type = START;
    end else if (enemy_cor != COORD_NONE) begin
      sample.evt_type = ENEMY;
      sample.x        = enemy_cor[7:4];
      sample.y        = enemy_cor[3:0];
    end else if (player_cor != COORD_NONE) begin
      sample.evt_type = PLAYER;
      sample.x        = player_cor[7:4];
      sample.y        = player_cor[3:0];
    end
    if (RANGE_CHECK && (sample.evt_type != START) && !in_range) begin
      sample = '0;
    end
  end

  assign sample_idle = (sample.evt_type == NONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      qcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      qcnt_q  <= qcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    qcnt_d  = qcnt_q;
    rcnt_d  = rcnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sample_idle) begin
          cand_d = sample;
          // A one-sample debounce qualifies on the very first edge.
          if (DEB == 4'd1) begin
            push    = 1'b1;
            state_d = ST_WAIT_REL;
            qcnt_d  = 4'd0;
            rcnt_d  = 4'd0;
          end else begin
            qcnt_d  = 4'd1;
            state_d = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (sample_idle) begin
          state_d = ST_IDLE;
          qcnt_d  = 4'd0;
        end else if (sample == cand_q) begin
          if ((qcnt_q + 4'd1) == DEB) begin
            push    = 1'b1;
            state_d = ST_WAIT_REL;
            qcnt_d  = 4'd0;
            rcnt_d  = 4'd0;
          end else begin
            qcnt_d = qcnt_q + 4'd1;
          end
        end else begin
          cand_d = sample;
          qcnt_d = 4'd1;
        end
      end
      ST_WAIT_REL: begin
        if (!sample_idle) begin
          rcnt_d = 4'd0;
        end else if ((rcnt_q + 4'd1) == DEB) begin
          state_d = ST_IDLE;
          rcnt_d  = 4'd0;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        qcnt_d  = 4'd0;
        rcnt_d  = 4'd0;
      end
    endcase
  end

  assign pop = evt_valid && evt_ready;

  click_fifo #(
    .T(click_evt_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(sample),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The FSM has already moved on; a dropped event is only reported here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && fifo_full && !pop;
    end
  end

  assign evt_valid    = !fifo_empty;
  assign evt_type     = head.evt_type;
  assign evt_x        = head.x;
  assign evt_y        = head.y;
  assign evt_overflow = overflow_q;

endmodule

// File: tb/tb_board_click_rx.sv
// tb/tb_board_click_rx.sv - directed and randomized checks of board_click_rx against a run-length event model
module tb_board_click_rx;

  localparam int DEB  = 4;
  localparam int GRID = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic [7:0] player_cor = 8'hFF;
  logic [7:0] enemy_cor = 8'hFF;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [3:0] evt_x;
  logic [3:0] evt_y;
  logic       evt_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: event = {type[1:0], x[3:0], y[3:0]}; 0 means no click.
  logic [9:0] mq[$];
  logic [9:0] prev_s;
  int         run_len;
  bit         armed;
  bit         exp_ovf;
  bit         rst_edge;
  int         valid_cycles;
  int         ovf_pulses;

  always #5 clk = ~clk;

  board_click_rx #(
    .DEBOUNCE_CYCLES(DEB),
    .GRID_CELLS     (GRID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .player_cor  (player_cor),
    .enemy_cor   (enemy_cor),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_x       (evt_x),
    .evt_y       (evt_y),
    .evt_overflow(evt_overflow)
  );

  function automatic logic [9:0] samp(logic s, logic [7:0] e, logic [7:0] p);
    logic [7:0] c;
    logic [1:0] t;
    if (s) return {2'd1, 8'h00};
    if (e != 8'hFF) begin
      t = 2'd3; c = e;
    end else if (p != 8'hFF) begin
      t = 2'd2; c = p;
    end else begin
      return 10'd0;
    end
`ifdef CLICK_RX_RANGE_CHECK_EN
    if (int'(c[7:4]) >= GRID || int'(c[3:0]) >= GRID) return 10'd0;
`endif
    return {t, c};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(evt_valid), 32'(mq.size() > 0));
    chk("overflow", 32'(evt_overflow), 32'(exp_ovf));
    if (mq.size() > 0)
      chk("head", 32'({evt_type, evt_x, evt_y}), 32'(mq[0]));
    else if (rst_edge)
      chk("reset_fields", 32'({evt_type, evt_x, evt_y}), 32'd0);
    if (evt_valid === 1'b1) valid_cycles++;
    if (evt_overflow === 1'b1) ovf_pulses++;
  endtask

  // One clock: capture pre-edge inputs, advance the model, then check just after the edge.
  task automatic step();
    logic [9:0] s;
    bit         pop;
    bit         emit;
    s        = samp(start_btn, enemy_cor, player_cor);
    pop      = (mq.size() > 0) && evt_ready;
    rst_edge = !rst_n;
    @(posedge clk);
    exp_ovf = 1'b0;
    if (rst_edge) begin
      mq.delete();
      run_len = 0;
      prev_s  = 10'd0;
      armed   = 1'b1;
    end else begin
      if (run_len > 0 && s == prev_s) run_len++;
      else run_len = 1;
      prev_s = s;
      emit   = 1'b0;
      // A press fires once when its run of identical samples hits DEB; N idle samples re-arm.
      if (s != 10'd0 && armed && run_len == DEB) begin
        emit  = 1'b1;
        armed = 1'b0;
      end else if (s == 10'd0 && !armed && run_len == DEB) begin
        armed = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (emit) begin
        if (mq.size() < 2) mq.push_back(s);
        else exp_ovf = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    start_btn  = 1'b0;
    enemy_cor  = 8'hFF;
    player_cor = 8'hFF;
  endtask

  initial begin
    int r;
    int hold;
    run_len = 0;
    prev_s  = 10'd0;
    armed   = 1'b1;
    exp_ovf = 1'b0;

    // Reset state
    rst_n = 1'b0;
    run(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ovf", 32'(evt_overflow), 32'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;

    // Enemy 0x35 held 10 cycles: valid right after 4th edge, for one cycle
    valid_cycles = 0;
    enemy_cor = 8'h35;
    run(3);
    chk("enemy_pre", 32'(evt_valid), 32'd0);
    step();
    chk("enemy_valid", 32'(evt_valid), 32'd1);
    chk("enemy_fields", 32'({evt_type, evt_x, evt_y}), 32'({2'd3, 4'd3, 4'd5}));
    run(6);
    chk("enemy_once", 32'(valid_cycles), 32'd1);
    idle_inputs();
    run(5);

    // Bouncing player click never qualifies
    valid_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      player_cor = 8'h21;
      run(2);
      player_cor = 8'hFF;
      run(2);
    end
    chk("bounce_none", 32'(valid_cycles), 32'd0);
    run(5);

    // Three presses with a stalled consumer: third is dropped
    evt_ready  = 1'b0;
    ovf_pulses = 0;
    start_btn = 1'b1;   run(5); idle_inputs(); run(4);
    player_cor = 8'h11; run(5); idle_inputs(); run(4);
    player_cor = 8'h22; run(5); idle_inputs(); run(4);
    chk("ovf_once", 32'(ovf_pulses), 32'd1);
    chk("full_head", 32'({evt_type, evt_x, evt_y}), 32'({2'd1, 8'h00}));
    evt_ready = 1'b1;
    step();
    chk("second_head", 32'({evt_type, evt_x, evt_y}), 32'({2'd2, 4'd1, 4'd1}));
    step();
    chk("drained", 32'(evt_valid), 32'd0);

    // Start beats enemy
    valid_cycles = 0;
    start_btn = 1'b1;
    enemy_cor = 8'h44;
    run(4);
    chk("prio_fields", 32'({evt_type, evt_x, evt_y}), 32'({2'd1, 8'h00}));
    run(2);
    idle_inputs();
    run(5);
    chk("prio_once", 32'(valid_cycles), 32'd1);

    // Out-of-grid enemy cell
    valid_cycles = 0;
    enemy_cor = 8'hC2;
    run(4);
`ifdef CLICK_RX_RANGE_CHECK_EN
    chk("range_none", 32'(evt_valid), 32'd0);
`else
    chk("range_pass", 32'({evt_valid, evt_type, evt_x, evt_y}), 32'({1'b1, 2'd3, 4'd12, 4'd2}));
`endif
    run(2);
    idle_inputs();
    run(5);

    // Reset mid-qualification with one event pending
    evt_ready = 1'b0;
    start_btn = 1'b1; run(5); idle_inputs(); run(4);
    chk("pending", 32'(evt_valid), 32'd1);
    enemy_cor = 8'h35;
    run(2);
    rst_n = 1'b0;
    step();
    chk("rst_discard", 32'(evt_valid), 32'd0);
    rst_n = 1'b1;
    run(3);
    chk("requal_pre", 32'(evt_valid), 32'd0);
    step();
    chk("requal_fields", 32'({evt_valid, evt_type, evt_x, evt_y}), 32'({1'b1, 2'd3, 4'd3, 4'd5}));
    evt_ready = 1'b1;
    idle_inputs();
    run(6);

    // Randomized held clicks, consumer stalls and occasional resets
    for (int k = 0; k < 140; k++) begin
      r    = $urandom_range(0, 9);
      hold = $urandom_range(1, 7);
      start_btn  = (r == 0);
      enemy_cor  = (r >= 1 && r <= 3) ? {4'($urandom_range(0, 13)), 4'($urandom_range(0, 13))} : 8'hFF;
      player_cor = (r >= 2 && r <= 6) ? {4'($urandom_range(0, 13)), 4'($urandom_range(0, 13))} : 8'hFF;
      evt_ready  = ($urandom_range(0, 2) != 0);
      rst_n      = (k % 37 != 36);
      run(hold);
      rst_n = 1'b1;
    end
    idle_inputs();
    evt_ready = 1'b1;
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
